// File: rtl/alu_seq.sv
// alu_seq: registered valid/ready ALU; iterative MUL/MULHU enabled by ALU_SEQ_MUL_EN
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHIFT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {IDLE, DONE, MUL_BUSY} state_t;
`else
  typedef enum logic {IDLE, DONE} state_t;
`endif
  state_t state_q, state_d;
  logic [WIDTH-1:0] alu_res, ld_val;
  logic [SHIFT_W-1:0] sh;
  logic accept, is_mul, ld_en;
  assign sh = op2[SHIFT_W-1:0];
  assign in_ready = state_q == IDLE || (state_q == DONE && out_ready);
  assign out_valid = state_q == DONE;
  assign accept = in_valid && in_ready;
  always_comb begin
    alu_res = '0;
    case (alu_op)
      4'b0000: alu_res = op1 & op2;
      4'b0001: alu_res = op1 | op2;
      4'b0010: alu_res = op1 + op2;
      4'b0110: alu_res = op1 - op2;
      4'b0101: alu_res = op1 ^ op2;
      4'b0100: alu_res = {{(WIDTH-1){1'b0}}, op1 < op2};
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
      4'b1000: alu_res = op1 << sh;
      4'b1001: alu_res = op1 >> sh;
      4'b1010: alu_res = $signed(op1) >>> sh;
      default: alu_res = '0;
    endcase
  end
`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] mcand, acc, acc_nx;
  logic [WIDTH-1:0] mplier, mul_res;
  logic [SHIFT_W-1:0] cnt;
  logic mul_hi, mul_done;
  assign is_mul = alu_op[3:1] == 3'b110;
  assign acc_nx = acc + (mplier[0] ? mcand : '0);
  assign mul_res = mul_hi ? acc_nx[2*WIDTH-1:WIDTH] : acc_nx[WIDTH-1:0];
  assign mul_done = state_q == MUL_BUSY && cnt == SHIFT_W'(WIDTH-1);
  assign ld_en = mul_done || (accept && !is_mul);
  assign ld_val = mul_done ? mul_res : alu_res;
  // One multiplier bit per edge, LSB first; the last step's sum is the full product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      acc <= '0;
      mplier <= '0;
      cnt <= '0;
      mul_hi <= 1'b0;
    end else if (accept && is_mul) begin
      mcand <= {{WIDTH{1'b0}}, op1};
      acc <= '0;
      mplier <= op2;
      cnt <= '0;
      mul_hi <= alu_op[0];
    end else if (state_q == MUL_BUSY) begin
      mcand <= mcand << 1;
      acc <= acc_nx;
      mplier <= mplier >> 1;
      cnt <= cnt + SHIFT_W'(1);
    end
  end
`else
  assign is_mul = 1'b0;
  assign ld_en = accept;
  assign ld_val = alu_res;
`endif
  always_comb begin
    state_d = state_q;
    if (accept) state_d = DONE;
    else if (state_q == DONE && out_ready) state_d = IDLE;
`ifdef ALU_SEQ_MUL_EN
    if (accept && is_mul) state_d = MUL_BUSY;
    if (mul_done) state_d = DONE;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      result <= '0;
      zero <= 1'b1;
    end else begin
      state_q <= state_d;
      if (ld_en) begin
        result <= ld_val;
        zero <= ld_val == '0;
      end
    end
  end
endmodule
